aes_inv_round_ctrl: RTL and testbench



---
 rtl/aes_inv_round_ctrl_if.sv | 35 +++
 rtl/aes_inv_round_ctrl.sv | 103 ++++++++++
 tb/tb_aes_inv_round_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_round_ctrl_if.sv
// Bundle for the AES inverse round controller.
// Covers the ciphertext-in and plaintext-out valid/ready streams,
// the round-key memory read port, the round datapath port and
// the busy flag.
// The slave modport is the controller's view; master is the surroundings.
interface aes_inv_round_ctrl_if #(
  parameter int KW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_block;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_block;
  logic          key_rd;
  logic [KW-1:0] key_addr;
  logic [127:0]  key_data;
  logic [127:0]  dp_state;
  logic [127:0]  dp_round_key;
  logic          dp_mix_en;
  logic [127:0]  dp_result;
  logic          busy;

  modport slave (
    input  in_valid, in_block, out_ready, key_data, dp_result,
    output in_ready, out_valid, out_block, key_rd, key_addr,
           dp_state, dp_round_key, dp_mix_en, busy
  );

  modport master (
    output in_valid, in_block, out_ready, key_data, dp_result,
    input  in_ready, out_valid, out_block, key_rd, key_addr,
           dp_state, dp_round_key, dp_mix_en, busy
  );
endinterface

// File: rtl/aes_inv_round_ctrl.sv
// Iterative sequencer for the AES inverse-cipher round datapath.
//
// The controller holds the 128-bit state and the round counter. It runs
// NR+1 FETCH/EXEC pairs, walking the round keys from NR down to 0.
// - The first EXEC (round NR) is the plain initial AddRoundKey.
// - Every later EXEC loads the shared combinational datapath's result.
// - InvMixColumns is enabled for rounds NR-1..1 only.
//
// Optional feature: define AES_DEC_ABORT_EN to add an `abort` input.
// abort drops any in-flight block and returns the controller to IDLE.
// It has no effect while the controller is already in IDLE.
//
// NR must be 10, 12 or 14, and 2^KW must exceed NR.
module aes_inv_round_ctrl #(
  parameter int NR = 10,
  parameter int KW = 4
) (
  input logic clk,
  input logic rst_n,
`ifdef AES_DEC_ABORT_EN
  input logic abort,
`endif
  aes_inv_round_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [KW-1:0] NR_R = KW'(NR);

  logic [1:0]    fsm_q, fsm_d;
  logic [KW-1:0] round_q, round_d;
  logic [127:0]  state_q, state_d;

  // Next-state, next-round and next-data decode for the sequencer.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no branch can leave one unassigned and infer a latch.
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;
    case (fsm_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = bus.in_block;
          round_d = NR_R;
          fsm_d   = FETCH;
        end
      end
      FETCH: fsm_d = EXEC;
      EXEC: begin
        // Round NR is the initial key whitening; the datapath output is unused then.
        state_d = (round_q == NR_R) ? (state_q ^ bus.key_data) : bus.dp_result;
        if (round_q == '0) begin
          fsm_d = DONE;
        end else begin
          round_d = round_q - KW'(1);
          fsm_d   = FETCH;
        end
      end
      DONE: begin
        if (bus.out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
`ifdef AES_DEC_ABORT_EN
    // abort overrides every transition except those taken from IDLE.
    if (abort && (fsm_q != IDLE)) begin
      fsm_d   = IDLE;
      round_d = '0;
      state_d = '0;
    end
`endif
  end

  // State, round counter and FSM registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers take non-blocking assignments so all of them see pre-edge values in the same cycle.
    if (!rst_n) begin
      fsm_q   <= IDLE;
      round_q <= '0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
    end
  end

  // Outputs are decoded straight from the registers.
  // They therefore take their reset values as soon as rst_n falls.
  assign bus.in_ready     = (fsm_q == IDLE);
  assign bus.busy         = (fsm_q == FETCH) || (fsm_q == EXEC);
  assign bus.out_valid    = (fsm_q == DONE);
  assign bus.out_block    = state_q;
  assign bus.key_rd       = (fsm_q == FETCH);
  assign bus.key_addr     = (fsm_q == FETCH) ? round_q : '0;
  assign bus.dp_state     = state_q;
  assign bus.dp_round_key = bus.key_data;
  assign bus.dp_mix_en    = (fsm_q == EXEC) && (round_q != '0) && (round_q != NR_R);

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Self-checking bench for aes_inv_round_ctrl with NR=10 (AES-128).
//
// The bench provides the expanded-key memory, which returns data one cycle
// after key_rd. It also provides a behavioural model of the inverse round
// datapath.
//
// Expected plaintexts come from two sources:
// - the FIPS-197 appendix vector;
// - a forward AES encryption of random plaintexts, from which the
//   controller must recover the original.
//
// Define AES_DEC_ABORT_EN to also exercise the abort input.
module tb_aes_inv_round_ctrl;
  localparam int NR = 10;
  localparam int KW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
`ifdef AES_DEC_ABORT_EN
  logic abort = 1'b0;
`endif

  aes_inv_round_ctrl_if #(.KW(KW)) bus ();

  aes_inv_round_ctrl #(.NR(NR), .KW(KW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef AES_DEC_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]   sbox     [256];
  logic [7:0]   inv_sbox [256];
  logic [127:0] key_mem  [1<<KW];
  logic [KW-1:0] addr_q [$];
  logic          mix_q  [$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- GF(2^8) and AES helpers ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box built from its definition: multiplicative inverse, then affine map.
  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] a8;
    for (int a = 0; a < 256; a++) begin
      a8  = 8'(a);
      inv = 8'h00;
      if (a != 0) begin
        inv = 8'h01;
        for (int n = 0; n < 254; n++) inv = gmul(inv, a8);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
          {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[a]     = s;
      inv_sbox[s] = a8;
    end
  endtask

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_all(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv ? inv_sbox[gb(s, i)] : sbox[gb(s, i)];
    return o;
  endfunction

  // Byte 4c+r is row r, column c. Forward: s'[r][c] = s[r][c+r]; inverse: s[r][c-r].
  function automatic logic [127:0] shift_all(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
        o[127-8*(4*c+r) -: 8] = gb(s, 4*src + r);
      end
    return o;
  endfunction

  // Circulant column mix with first-row coefficients k0..k3.
  function automatic logic [127:0] mix_all(input logic [127:0] s, input logic [7:0] k0,
                                           input logic [7:0] k1, input logic [7:0] k2,
                                           input logic [7:0] k3);
    logic [127:0] o;
    logic [7:0]   cf [4];
    logic [7:0]   acc;
    cf[0] = k0; cf[1] = k1; cf[2] = k2; cf[3] = k3;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(cf[(k - r + 4) % 4], gb(s, 4*c + k));
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  // AES-128 key schedule into key_mem[0..10].
  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k <= NR; k++) key_mem[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  // Forward cipher using key_mem; used to produce ciphertexts whose plaintext is known.
  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ key_mem[0];
    for (int r = 1; r < NR; r++)
      s = mix_all(shift_all(sub_all(s, 1'b0), 1'b0), 8'h02, 8'h03, 8'h01, 8'h01) ^ key_mem[r];
    return shift_all(sub_all(s, 1'b0), 1'b0) ^ key_mem[NR];
  endfunction

  // One inverse round as the shared datapath would compute it.
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic m);
    logic [127:0] t;
    t = sub_all(shift_all(s, 1'b1), 1'b1) ^ k;
    return m ? mix_all(t, 8'h0e, 8'h0b, 8'h0d, 8'h09) : t;
  endfunction

  // ---------------- environment ----------------
  // Key memory: data appears the cycle after the strobe.
  always @(posedge clk) if (bus.key_rd) bus.key_data <= key_mem[bus.key_addr];

  assign bus.dp_result = inv_round(bus.dp_state, bus.dp_round_key, bus.dp_mix_en);

  // Record key-access order and the InvMixColumns enable of every EXEC cycle.
  always @(negedge clk) begin
    if (bus.key_rd) addr_q.push_back(bus.key_addr);
    if (bus.busy && !bus.key_rd) mix_q.push_back(bus.dp_mix_en);
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- sequences ----------------
  // Entered at the negedge right after the accepting edge.
  // Returns at the negedge after the output handshake, with the controller in IDLE.
  task automatic finish_block(input string tag, input logic [127:0] pt, input int base_a,
                              input int base_m, input int hold);
    int edges;
    logic [127:0] rnd;
    edges = 0;
    while (!bus.out_valid && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    check({tag, "_latency"}, 128'(edges), 128'(2*(NR+1)));
    check({tag, "_data"}, bus.out_block, pt);
    check({tag, "_key_count"}, 128'(addr_q.size() - base_a), 128'(NR+1));
    check({tag, "_exec_count"}, 128'(mix_q.size() - base_m), 128'(NR+1));
    for (int i = 0; i <= NR; i++) begin
      if (base_a + i < addr_q.size())
        check({tag, "_key_addr"}, 128'(addr_q[base_a+i]), 128'(NR-i));
      if (base_m + i < mix_q.size())
        check({tag, "_mix_en"}, 128'(mix_q[base_m+i]), 128'((NR-i != 0) && (NR-i != NR)));
    end
    for (int i = 0; i < hold; i++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.in_valid = i[0];
      bus.in_block = rnd;
      @(negedge clk);
      check({tag, "_bp_valid"}, 128'(bus.out_valid), 128'(1));
      check({tag, "_bp_data"}, bus.out_block, pt);
      check({tag, "_bp_in_ready"}, 128'(bus.in_ready), 128'(0));
    end
    if (hold > 0) bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_ready_after"}, 128'(bus.in_ready), 128'(1));
    check({tag, "_valid_after"}, 128'(bus.out_valid), 128'(0));
  endtask

  task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] pt,
                           input int hold);
    int base_a;
    int base_m;
    check({tag, "_idle_ready"}, 128'(bus.in_ready), 128'(1));
    base_a = addr_q.size();
    base_m = mix_q.size();
    bus.out_ready = (hold == 0);
    bus.in_valid  = 1'b1;
    bus.in_block  = ct;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, "_busy"}, 128'(bus.busy), 128'(1));
    finish_block(tag, pt, base_a, base_m, hold);
  endtask

  task automatic wait_fetch(input string tag, input int r);
    int n;
    n = 0;
    while (!(bus.key_rd && int'(bus.key_addr) == r) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_reach_fetch"}, 128'(n < 100), 128'(1));
  endtask

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  initial begin
    logic [127:0] pt_b;
    logic [127:0] ct_b;
    logic [127:0] key;
    int base_a;
    int base_m;
    int seen;

    build_tables();
    expand_key(FIPS_KEY);
    bus.in_valid  = 1'b0;
    bus.in_block  = '0;
    bus.out_ready = 1'b0;

    // Reset values while rst_n is low.
    repeat (2) @(negedge clk);
    check("rst_in_ready", 128'(bus.in_ready), 128'(1));
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_key_rd", 128'(bus.key_rd), 128'(0));
    check("rst_key_addr", 128'(bus.key_addr), 128'(0));
    check("rst_mix_en", 128'(bus.dp_mix_en), 128'(0));
    check("rst_out_block", bus.out_block, 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 vector with 5 cycles of output backpressure.
    run_block("fips", FIPS_CT, FIPS_PT, 5);

    // Back-to-back blocks: in_valid held high, out_ready tied high.
    pt_b = {$urandom(), $urandom(), $urandom(), $urandom()};
    ct_b = encrypt(pt_b);
    bus.out_ready = 1'b1;
    base_a = addr_q.size();
    base_m = mix_q.size();
    bus.in_valid = 1'b1;
    bus.in_block = FIPS_CT;
    @(negedge clk);
    bus.in_block = ct_b;
    check("b2b_a_busy", 128'(bus.busy), 128'(1));
    finish_block("b2b_a", FIPS_PT, base_a, base_m, 0);
    base_a = addr_q.size();
    base_m = mix_q.size();
    @(negedge clk);
    check("b2b_second_accept", 128'(bus.busy), 128'(1));
    bus.in_valid = 1'b0;
    finish_block("b2b_b", pt_b, base_a, base_m, 0);

    // Reset asserted during EXEC of round 5, then a fresh block.
    bus.in_valid = 1'b1;
    bus.in_block = FIPS_CT;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_fetch("mid_rst", 5);
    @(negedge clk);
    check("mid_rst_exec_mix", 128'(bus.dp_mix_en), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 128'(bus.in_ready), 128'(1));
    check("mid_rst_busy", 128'(bus.busy), 128'(0));
    check("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("mid_rst_key_rd", 128'(bus.key_rd), 128'(0));
    check("mid_rst_key_addr", 128'(bus.key_addr), 128'(0));
    check("mid_rst_mix_en", 128'(bus.dp_mix_en), 128'(0));
    check("mid_rst_state", bus.dp_state, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_block("post_rst", FIPS_CT, FIPS_PT, 0);

    // Random keys and plaintexts, recovered from their forward encryption.
    for (int t = 0; t < 4; t++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      expand_key(key);
      pt_b = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_block($sformatf("rand%0d", t), encrypt(pt_b), pt_b, int'($urandom_range(0, 3)));
    end

`ifdef AES_DEC_ABORT_EN
    expand_key(FIPS_KEY);
    // Abort during FETCH of round 3.
    bus.in_valid = 1'b1;
    bus.in_block = FIPS_CT;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_fetch("abort", 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_in_ready", 128'(bus.in_ready), 128'(1));
    check("abort_busy", 128'(bus.busy), 128'(0));
    check("abort_state", bus.out_block, 128'(0));
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    check("abort_no_out_valid", 128'(seen), 128'(0));

    // abort together with in_valid in IDLE: the block is still accepted.
    bus.out_ready = 1'b1;
    base_a = addr_q.size();
    base_m = mix_q.size();
    abort = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_block = FIPS_CT;
    @(negedge clk);
    abort = 1'b0;
    bus.in_valid = 1'b0;
    check("abort_idle_accept", 128'(bus.busy), 128'(1));
    finish_block("abort_idle", FIPS_PT, base_a, base_m, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
